rti_fifo_core: RTL and testbench
================================

RTI_FIFO_CORE -- requirements
Module: rti_fifo_core

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 128, width of the stored word.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, giving depth DEPTH = 2**ADDR_WIDTH words.
REQ-003 The block SHALL have parameter AF_THRESH, default DEPTH-4, the almost_full occupancy threshold, legal range 1..DEPTH.
REQ-004 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of contents and error state.
- write  input  1  push request.
- read  input  1  pop request.
- err_clear  input  1  synchronous clear of sticky error flags.
- rti_in  input  DATA_WIDTH  write data.
- rti_out  output  DATA_WIDTH  head word, first-word-fall-through.
- overflow_error_data  output  DATA_WIDTH  first rejected write word since last clear.
- overflow_error  output  1  one-cycle pulse, rejected write.
- underflow_error  output  1  one-cycle pulse, rejected read.
- overflow_sticky  output  1  latched overflow.
- underflow_sticky  output  1  latched underflow.
- full  output  1  occupancy == DEPTH.
- almost_full  output  1  occupancy >= AF_THRESH.
- empty  output  1  occupancy == 0.
- data_num  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Function
REQ-005 rti_out SHALL present the oldest stored word whenever empty==0; it is don't-care when empty==1.
REQ-006 A write SHALL be accepted when write==1 and either full==0 or an accepted read occurs in the same cycle.
REQ-007 A read SHALL be accepted when read==1 and empty==0; a write to an empty FIFO SHALL NOT bypass to a same-cycle read.
REQ-008 An accepted word SHALL appear on rti_out, with empty==0, one cycle after the write edge when the FIFO was empty.
REQ-009 data_num SHALL become +1 on write-only, -1 on read-only, and stay unchanged on both or neither; full, empty and almost_full SHALL be registered and consistent with data_num in the same cycle.
REQ-010 Pointers SHALL wrap modulo DEPTH; data_num SHALL never exceed DEPTH or go below 0.
REQ-011 A rejected write SHALL drop its data and pulse overflow_error for exactly one cycle, the cycle after the request.
REQ-012 A rejected read SHALL leave state unchanged and pulse underflow_error for exactly one cycle, the cycle after the request.
REQ-013 overflow_sticky and underflow_sticky SHALL set with their pulse and hold until err_clear, flush or reset.
REQ-014 overflow_error_data SHALL capture rti_in of the first rejected write while overflow_sticky==0, and hold it until cleared.
REQ-015 flush SHALL, at the next edge, zero both pointers, data_num, all error outputs and overflow_error_data; it SHALL override same-cycle write, read and error events.
REQ-016 If err_clear coincides with a new error, the new error SHALL win: the pulse fires and the sticky flag sets.

Reset
REQ-017 On reset assertion, asynchronously: data_num=0, empty=1, full=0, almost_full=0 (for AF_THRESH>=1), all error outputs=0, overflow_error_data=0.
REQ-018 Storage RAM contents SHALL NOT be reset; writes SHALL be ignored while reset is high.
REQ-019 Reset during a burst SHALL discard all contents; the first post-reset write SHALL be the first word read.

Structure
REQ-020 The DATA_WIDTH and ADDR_WIDTH defaults SHALL be constants in the shared package rti_pkg.
REQ-021 Storage SHALL be a sub-module rti_fifo_ram: simple dual-port, synchronous write, asynchronous read, no reset. No vendor FIFO IP SHALL be used.

Verification (DATA_WIDTH=128, ADDR_WIDTH=2, AF_THRESH=3)
REQ-022 Write 0x11,0x22,0x33,0x44 on consecutive cycles -> data_num 1,2,3,4; almost_full=1 at 3; full=1 at 4; then read 4 times -> rti_out 0x11,0x22,0x33,0x44 in order, empty=1.
REQ-023 On full, write 0xAA then 0xBB -> overflow_error pulses twice, overflow_sticky=1, overflow_error_data=0xAA, data_num=4; then err_clear -> sticky=0, data=0.
REQ-024 On full, assert read and write 0x55 together -> data_num stays 4, no overflow; after 4 reads the last word is 0x55.
REQ-025 On empty, assert read and write 0x77 together -> underflow_error pulses once, data_num=1, rti_out=0x77 next cycle.
REQ-026 With 3 words stored, assert flush with write -> data_num=0, empty=1 next cycle; a later write 0x99 is the next word read.
REQ-027 Assert reset mid-burst asynchronously -> empty=1 and data_num=0 without waiting for a clock edge; after reset, wraparound over 10 write/read pairs preserves data order.

Source files
------------

// File: rtl/rti_pkg.sv
// Shared constants for the RTI FIFO slice.
package rti_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 128;
    localparam int unsigned DEF_ADDR_WIDTH = 10;

endpackage : rti_pkg

// File: rtl/rti_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module rti_fifo_ram
    import rti_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port: contents are intentionally never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port is combinational so the head word falls through.
    assign rdata = mem[raddr];

endmodule : rti_fifo_ram

// File: rtl/rti_fifo_core.sv
// First-word-fall-through FIFO with registered status flags and
// pulse/sticky overflow and underflow reporting.
module rti_fifo_core
    import rti_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned AF_THRESH  = (2 ** ADDR_WIDTH) - 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  write,
    input  logic                  read,
    input  logic                  err_clear,
    input  logic [DATA_WIDTH-1:0] rti_in,
    output logic [DATA_WIDTH-1:0] rti_out,
    output logic [DATA_WIDTH-1:0] overflow_error_data,
    output logic                  overflow_error,
    output logic                  underflow_error,
    output logic                  overflow_sticky,
    output logic                  underflow_sticky,
    output logic                  full,
    output logic                  almost_full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   data_num
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_W-1:0]      num_next;
    logic                  rd_ok;
    logic                  wr_ok;
    logic                  ovf_req;
    logic                  unf_req;
    logic                  ram_we;

    // Accept/reject decisions and next occupancy; a read on an empty FIFO
    // is rejected even if a write lands in the same cycle (no bypass).
    always_comb begin
        rd_ok    = read && !empty;
        wr_ok    = write && (!full || rd_ok);
        ovf_req  = write && !wr_ok;
        unf_req  = read && !rd_ok;
        ram_we   = wr_ok && !flush && !reset;
        num_next = data_num;
        if (wr_ok && !rd_ok) begin
            num_next = data_num + CNT_W'(1);
        end else if (rd_ok && !wr_ok) begin
            num_next = data_num - CNT_W'(1);
        end
    end

    // Pointers, occupancy and flags derived from the next occupancy so
    // they stay mutually consistent every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            data_num    <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            data_num    <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            data_num    <= num_next;
            empty       <= (num_next == '0);
            full        <= (num_next == CNT_W'(DEPTH));
            almost_full <= (num_next >= CNT_W'(AF_THRESH));
        end
    end

    // Error pulses, sticky flags and first-overflow capture; a new error
    // takes priority over a coincident err_clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_error      <= 1'b0;
            underflow_error     <= 1'b0;
            overflow_sticky     <= 1'b0;
            underflow_sticky    <= 1'b0;
            overflow_error_data <= '0;
        end else if (flush) begin
            overflow_error      <= 1'b0;
            underflow_error     <= 1'b0;
            overflow_sticky     <= 1'b0;
            underflow_sticky    <= 1'b0;
            overflow_error_data <= '0;
        end else begin
            overflow_error  <= ovf_req;
            underflow_error <= unf_req;

            if (ovf_req) begin
                overflow_sticky <= 1'b1;
            end else if (err_clear) begin
                overflow_sticky <= 1'b0;
            end

            if (unf_req) begin
                underflow_sticky <= 1'b1;
            end else if (err_clear) begin
                underflow_sticky <= 1'b0;
            end

            if (ovf_req && (!overflow_sticky || err_clear)) begin
                overflow_error_data <= rti_in;
            end else if (err_clear) begin
                overflow_error_data <= '0;
            end
        end
    end

    rti_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (rti_in),
        .raddr (rd_ptr),
        .rdata (rti_out)
    );

endmodule : rti_fifo_core

// File: tb/tb_rti_fifo_core.sv
// Scoreboard bench for rti_fifo_core at DATA_WIDTH=128, ADDR_WIDTH=2, AF_THRESH=3.
module tb_rti_fifo_core;

    localparam int unsigned DW    = 128;
    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          write;
    logic          read;
    logic          err_clear;
    logic [DW-1:0] rti_in;
    logic [DW-1:0] rti_out;
    logic [DW-1:0] overflow_error_data;
    logic          overflow_error;
    logic          underflow_error;
    logic          overflow_sticky;
    logic          underflow_sticky;
    logic          full;
    logic          almost_full;
    logic          empty;
    logic [AW:0]   data_num;

    logic [DW-1:0] sb [$];
    logic          m_ovf;
    logic          m_unf;
    int            n_checks = 0;
    int            n_fail   = 0;

    rti_fifo_core #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .AF_THRESH  (3)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .flush               (flush),
        .write               (write),
        .read                (read),
        .err_clear           (err_clear),
        .rti_in              (rti_in),
        .rti_out             (rti_out),
        .overflow_error_data (overflow_error_data),
        .overflow_error      (overflow_error),
        .underflow_error     (underflow_error),
        .overflow_sticky     (overflow_sticky),
        .underflow_sticky    (underflow_sticky),
        .full                (full),
        .almost_full         (almost_full),
        .empty               (empty),
        .data_num            (data_num)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; the scoreboard tracks accepted words.
    task automatic drive(input logic w, input logic r, input logic f,
                         input logic ec, input logic [DW-1:0] d);
        bit rd_ok;
        bit wr_ok;
        write     = w;
        read      = r;
        flush     = f;
        err_clear = ec;
        rti_in    = d;
        rd_ok = r && (sb.size() != 0);
        wr_ok = w && ((sb.size() < DEPTH) || rd_ok);
        @(posedge clk);
        #1;
        if (reset || f) begin
            sb.delete();
        end else begin
            if (rd_ok) void'(sb.pop_front());
            if (wr_ok) sb.push_back(d);
        end
        m_ovf     = w && !wr_ok && !reset && !f;
        m_unf     = r && !rd_ok && !reset && !f;
        write     = 1'b0;
        read      = 1'b0;
        flush     = 1'b0;
        err_clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        n_checks++;
        if (empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0 || data_num !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_flags: empty=%b full=%b af=%b num=%0d, want 1 0 0 0",
                     empty, full, almost_full, data_num);
        end
        n_checks++;
        if (overflow_error !== 1'b0 || underflow_error !== 1'b0 || overflow_sticky !== 1'b0 ||
            underflow_sticky !== 1'b0 || overflow_error_data !== '0) begin
            n_fail++;
            $display("FAIL reset_errors: ovf=%b unf=%b ovs=%b uns=%b data=%h, want all 0",
                     overflow_error, underflow_error, overflow_sticky, underflow_sticky,
                     overflow_error_data);
        end
        reset = 1'b0;
    endtask

    task automatic test_fill_drain();
        logic [DW-1:0] vals [4];
        logic [DW-1:0] exp;
        vals[0] = DW'(8'h11); vals[1] = DW'(8'h22); vals[2] = DW'(8'h33); vals[3] = DW'(8'h44);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, vals[i]);
            n_checks++;
            if (data_num !== 3'(i + 1) || almost_full !== (i + 1 >= 3) ||
                full !== (i + 1 == 4) || empty !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_%0d: num=%0d af=%b full=%b empty=%b, want %0d %b %b 0",
                         i, data_num, almost_full, full, empty, i + 1, (i + 1 >= 3), (i + 1 == 4));
            end
            if (i == 0) begin
                n_checks++;
                if (rti_out !== DW'(8'h11)) begin
                    n_fail++;
                    $display("FAIL fwft_first: got %h want 11", rti_out);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            exp = sb[0];
            n_checks++;
            if (rti_out !== exp) begin
                n_fail++;
                $display("FAIL drain_%0d: got %h want %h", i, rti_out, exp);
            end
            drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
        end
        n_checks++;
        if (empty !== 1'b1 || data_num !== 3'd0) begin
            n_fail++;
            $display("FAIL drain_empty: empty=%b num=%0d, want 1 0", empty, data_num);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, DW'(8'hA1 + i));
        drive(1'b1, 1'b0, 1'b0, 1'b0, DW'(8'hAA));
        n_checks++;
        if (overflow_error !== m_ovf || overflow_error !== 1'b1 || overflow_sticky !== 1'b1 ||
            overflow_error_data !== DW'(8'hAA) || data_num !== 3'd4) begin
            n_fail++;
            $display("FAIL ovf_first: pulse=%b sticky=%b data=%h num=%0d, want 1 1 aa 4",
                     overflow_error, overflow_sticky, overflow_error_data, data_num);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, DW'(8'hBB));
        n_checks++;
        if (overflow_error !== 1'b1 || overflow_error_data !== DW'(8'hAA) || data_num !== 3'd4) begin
            n_fail++;
            $display("FAIL ovf_second: pulse=%b data=%h num=%0d, want 1 aa 4",
                     overflow_error, overflow_error_data, data_num);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        n_checks++;
        if (overflow_error !== 1'b0 || overflow_sticky !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_hold: pulse=%b sticky=%b, want 0 1", overflow_error, overflow_sticky);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
        n_checks++;
        if (overflow_sticky !== 1'b0 || overflow_error_data !== '0) begin
            n_fail++;
            $display("FAIL ovf_clear: sticky=%b data=%h, want 0 0", overflow_sticky, overflow_error_data);
        end
    endtask

    task automatic test_full_rw();
        logic [DW-1:0] exp;
        drive(1'b1, 1'b1, 1'b0, 1'b0, DW'(8'h55));
        n_checks++;
        if (data_num !== 3'd4 || full !== 1'b1 || overflow_error !== 1'b0) begin
            n_fail++;
            $display("FAIL full_rw: num=%0d full=%b ovf=%b, want 4 1 0", data_num, full, overflow_error);
        end
        for (int i = 0; i < 4; i++) begin
            exp = sb[0];
            n_checks++;
            if (rti_out !== exp || (i == 3 && rti_out !== DW'(8'h55))) begin
                n_fail++;
                $display("FAIL full_rw_read_%0d: got %h want %h", i, rti_out, exp);
            end
            drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
        end
    endtask

    task automatic test_empty_rw();
        drive(1'b1, 1'b1, 1'b0, 1'b0, DW'(8'h77));
        n_checks++;
        if (underflow_error !== m_unf || underflow_error !== 1'b1 || underflow_sticky !== 1'b1 ||
            data_num !== 3'd1 || rti_out !== DW'(8'h77) || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_rw: unf=%b sticky=%b num=%0d out=%h empty=%b, want 1 1 1 77 0",
                     underflow_error, underflow_sticky, data_num, rti_out, empty);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        n_checks++;
        if (underflow_error !== 1'b0 || underflow_sticky !== 1'b1) begin
            n_fail++;
            $display("FAIL unf_pulse_end: pulse=%b sticky=%b, want 0 1", underflow_error, underflow_sticky);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
        // err_clear together with a new underflow: the new error wins
        drive(1'b0, 1'b1, 1'b0, 1'b1, '0);
        n_checks++;
        if (underflow_error !== 1'b1 || underflow_sticky !== 1'b1 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL unf_vs_clear: pulse=%b sticky=%b empty=%b, want 1 1 1",
                     underflow_error, underflow_sticky, empty);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
        n_checks++;
        if (underflow_sticky !== 1'b0 || underflow_error !== 1'b0) begin
            n_fail++;
            $display("FAIL unf_clear: sticky=%b pulse=%b, want 0 0", underflow_sticky, underflow_error);
        end
    endtask

    task automatic test_flush();
        logic [DW-1:0] exp;
        drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, DW'(8'hC1 + i));
        drive(1'b1, 1'b0, 1'b1, 1'b0, DW'(8'hEE));
        n_checks++;
        if (data_num !== 3'd0 || empty !== 1'b1 || almost_full !== 1'b0 ||
            underflow_sticky !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL flush: num=%0d empty=%b af=%b usticky=%b, want 0 1 0 0",
                     data_num, empty, almost_full, underflow_sticky);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, DW'(8'h99));
        exp = sb[0];
        n_checks++;
        if (rti_out !== exp || exp !== DW'(8'h99) || data_num !== 3'd1) begin
            n_fail++;
            $display("FAIL post_flush: out=%h num=%0d, want 99 1", rti_out, data_num);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
    endtask

    task automatic test_reset_burst_wrap();
        logic [DW-1:0] exp;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, DW'(8'hD1 + i));
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (empty !== 1'b1 || data_num !== 3'd0 || almost_full !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: empty=%b num=%0d af=%b, want 1 0 0", empty, data_num, almost_full);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, DW'(8'hDD));
        n_checks++;
        if (empty !== 1'b1 || data_num !== 3'd0) begin
            n_fail++;
            $display("FAIL write_in_reset: empty=%b num=%0d, want 1 0", empty, data_num);
        end
        reset = 1'b0;
        sb.delete();
        for (int i = 0; i <= 10; i++) begin
            if (i > 0) begin
                exp = sb[0];
                n_checks++;
                if (rti_out !== exp) begin
                    n_fail++;
                    $display("FAIL wrap_%0d: got %h want %h", i, rti_out, exp);
                end
            end
            drive(i < 10, i > 0, 1'b0, 1'b0, DW'(32'hC0DE_0000 + i));
        end
        n_checks++;
        if (empty !== 1'b1 || data_num !== 3'd0) begin
            n_fail++;
            $display("FAIL wrap_end: empty=%b num=%0d, want 1 0", empty, data_num);
        end
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        write     = 1'b0;
        read      = 1'b0;
        err_clear = 1'b0;
        rti_in    = '0;
        m_ovf     = 1'b0;
        m_unf     = 1'b0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_full_rw();
        test_empty_rw();
        test_flush();
        test_reset_burst_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rti_fifo_core
